// File: rtl/wb_port_scheduler.sv
// wb_port_scheduler
//   Arbitrates the single register-file write port between the main pipeline
//   (primary: one write per cycle, cannot be backpressured) and a multi-cycle
//   side unit (secondary: late loads, IN, interrupt restore).
//   Secondary writes wait in a small FIFO. They drain on cycles with no
//   primary request. The grant decision is registered, so the wb_* outputs
//   describe the request made one cycle earlier.
//
//   Optional feature, selected by the macro WB_STARVE_GUARD_EN:
//     defined     - starve_cnt counts the cycles in which the FIFO head is
//                   denied. When it reaches STARVE_LIMIT the head is forced
//                   onto the port and pipe_stall holds the pipeline for that
//                   one slot.
//     not defined - no starvation counter and pipe_stall is tied low. The
//                   secondary queue drains only on idle primary cycles.
//
//   Handshake: a secondary request transfers on any rising edge where
//   s_valid && s_ready. s_ready is the registered "not full" flag. A pop in
//   the same cycle does not open a slot early. The side unit keeps s_rd and
//   s_data stable while s_valid is high and s_ready is low.
module wb_port_scheduler #(
  parameter int DATA_W       = 16,
  parameter int RA_W         = 3,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p_valid,
  input  logic [1:0]        p_sel,
  input  logic [RA_W-1:0]   p_rd,
  input  logic              p_out_en,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [RA_W-1:0]   s_rd,
  input  logic [DATA_W-1:0] s_data,
  output logic              pipe_stall,
  output logic [1:0]        wb_sel,
  output logic [RA_W-1:0]   wb_rd,
  output logic              wb_we,
  output logic              wb_src,
  output logic [DATA_W-1:0] wb_data,
  output logic              outport_en
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PRI  = 2'd1,
    GNT_SEC  = 2'd2
  } grant_e;

  grant_e grant;

  logic [RA_W-1:0]   q_rd   [FIFO_DEPTH];
  logic [DATA_W-1:0] q_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic force_sec;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign s_ready    = !fifo_full;
  assign push       = s_valid && s_ready;
  assign pop        = (grant == GNT_SEC);

`ifdef WB_STARVE_GUARD_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;

  assign force_sec = !fifo_empty && (starve_cnt == LIMIT);

  // Count the consecutive cycles in which a waiting head is denied. The
  // count saturates at the limit and clears when the head pops or the
  // FIFO is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (pop || fifo_empty) begin
      starve_cnt <= '0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`else
  assign force_sec = 1'b0;
`endif

  // The pipeline stalls only when a forced secondary grant takes a slot
  // that the primary wanted.
  assign pipe_stall = force_sec && p_valid;

  // Port grant priority: forced secondary first, then primary, then
  // opportunistic secondary drain.
  always_comb begin
    grant = GNT_NONE;
    if (force_sec) begin
      grant = GNT_SEC;
    end else if (p_valid) begin
      grant = GNT_PRI;
    end else if (!fifo_empty) begin
      grant = GNT_SEC;
    end
  end

  // FIFO storage. Entries are not reset because they are only read while
  // count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wr_ptr]   <= s_rd;
      q_data[wr_ptr] <= s_data;
    end
  end

  // FIFO pointers and occupancy. Pointers wrap naturally because
  // FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Register the granted write so the mux, RF write and outport enable
  // line up one cycle after the request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_we      <= 1'b0;
      wb_src     <= 1'b0;
      wb_sel     <= 2'b00;
      wb_rd      <= '0;
      wb_data    <= '0;
      outport_en <= 1'b0;
    end else begin
      case (grant)
        GNT_PRI: begin
          wb_we      <= 1'b1;
          wb_src     <= 1'b0;
          wb_sel     <= p_sel;
          wb_rd      <= p_rd;
          outport_en <= p_out_en;
        end
        GNT_SEC: begin
          wb_we      <= 1'b1;
          wb_src     <= 1'b1;
          wb_sel     <= 2'b01;
          wb_rd      <= q_rd[rd_ptr];
          wb_data    <= q_data[rd_ptr];
          outport_en <= 1'b0;
        end
        default: begin
          wb_we      <= 1'b0;
          wb_src     <= 1'b0;
          outport_en <= 1'b0;
        end
      endcase
    end
  end

endmodule
